fifo_stream_rd: RTL and testbench

//  Read-side controller for the 8x8 synchronous FIFO. It pops words through the FIFO's
//  rd/empty/q port, where q is registered and valid one cycle after rd, and presents

---
 rtl/fifo_pkg.sv | 6 +
 rtl/fifo_stream_rd_obuf2.sv | 32 +++
 rtl/fifo_syn.sv | 44 ++++
 rtl/fifo_stream_rd.sv | 53 +++++
 tb/tb_fifo_stream_rd.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared widths and word type for the synchronous FIFO and its stream reader
package fifo_pkg;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_DEPTH = 8;
    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_stream_rd_obuf2.sv
// obuf2: 2-entry ordered output buffer; head holds its value once drained
module obuf2
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] tail;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            occ <= occ + 2'(push) - 2'(pop);
            if (pop && occ == 2'd2) head <= tail;
            // new word lands in head only if head is free after this edge
            if (push && (occ == 2'd0 || (pop && occ == 2'd1))) head <= din;
            else if (push) tail <= din;
        end
    end
endmodule

// File: rtl/fifo_syn.sv
// fifo_syn: synchronous FIFO with registered read data, valid the cycle after rd
module fifo_syn
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd,
    output logic             empty,
    output logic [WIDTH-1:0] q
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic wr_ok, rd_ok;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            q   <= '0;
        end else begin
            if (wr_ok) wp <= (wp == AW'(DEPTH-1)) ? '0 : wp + AW'(1);
            if (rd_ok) begin
                q  <= mem[rp];
                rp <= (rp == AW'(DEPTH-1)) ? '0 : rp + AW'(1);
            end
            cnt <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
endmodule

// File: rtl/fifo_stream_rd.sv
// fifo_stream_rd: pops the FIFO and presents words as a valid/ready stream with burst framing
module fifo_stream_rd
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    output logic             fifo_rd,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy
);
    localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST_LEN - 1);
    logic infl, pop;
    logic [1:0] occ;
    logic [BC_W-1:0] beat_cnt;
    assign m_valid = occ != 2'd0;
    assign pop     = m_valid & m_ready;
    // issue only if the word will still have a slot when it arrives
    assign fifo_rd = ~fifo_empty & ~flush & (({1'b0, occ} + 3'(infl)) < (3'd2 + 3'(pop)));
    assign m_last  = m_valid & (beat_cnt == LAST_BEAT);
    assign busy    = m_valid | infl;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl     <= 1'b0;
            beat_cnt <= '0;
        end else if (flush) begin
            infl     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            infl <= fifo_rd;
            if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BC_W'(1);
        end
    end
    obuf2 #(.WIDTH(WIDTH)) u_obuf (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .push (infl & ~flush),
        .din  (fifo_q),
        .pop  (pop),
        .head (m_data),
        .occ  (occ)
    );
endmodule

// File: tb/tb_fifo_stream_rd.sv
// tb_fifo_stream_rd: directed bench for fifo_stream_rd behind fifo_syn, scoreboard-checked
module tb_fifo_stream_rd;
    import fifo_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic wr = 1'b0;
    logic m_ready = 1'b0;
    fifo_word_t din = '0;
    logic fifo_rd, fifo_empty, full, m_valid, m_last, busy;
    fifo_word_t fifo_q, m_data;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bc = 0;
    int pops = 0;
    int first_pop = 0;
    int last_pop = 0;
    int t_ne = -1;
    int t_v = -1;
    int n = 0;
    logic arm = 1'b0;
    logic hold = 1'b0;
    logic hold_l = 1'b0;
    logic flush_on_valid = 1'b0;
    logic post_flush = 1'b0;
    logic w3;
    fifo_word_t hold_d;
    fifo_word_t exp_q[$];

    always #5 clk = ~clk;

    fifo_syn #(.WIDTH(8), .DEPTH(8)) u_fifo (
        .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .full(full),
        .rd(fifo_rd), .empty(fifo_empty), .q(fifo_q)
    );

    fifo_stream_rd #(.WIDTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_rd(fifo_rd),
        .fifo_empty(fifo_empty), .fifo_q(fifo_q), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input fifo_word_t d, input logic r, input logic f);
        @(posedge clk);
        #1;
        cyc++;
        if (hold) begin
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data", 32'(m_data), 32'(hold_d));
            chk("hold_last", 32'(m_last), 32'(hold_l));
        end
        if (post_flush) begin
            chk("post_flush_valid", 32'(m_valid), 0);
            post_flush = 1'b0;
        end
        wr = w & ~full;
        din = d;
        m_ready = r;
        flush = f | (flush_on_valid & m_valid);
        if (wr) exp_q.push_back(d);
        #1;
        if (arm && t_ne < 0 && !fifo_empty) t_ne = cyc;
        if (arm && t_v < 0 && m_valid) t_v = cyc;
        if (fifo_empty) chk("rd_when_empty", 32'(fifo_rd), 0);
        hold = m_valid & ~m_ready & ~flush;
        hold_d = m_data;
        hold_l = m_last;
        if (flush) begin
            if (flush_on_valid) begin
                chk("flush_head", 32'(m_data), 32'(exp_q[0]));
                chk("flush_busy", 32'(busy), 1);
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
                flush_on_valid = 1'b0;
                post_flush = 1'b1;
            end
            bc = 0;
        end else if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_beat", 32'(m_valid), 0);
            else chk("data", 32'(m_data), 32'(exp_q.pop_front()));
            chk("last", 32'(m_last), 32'(bc == 3));
            bc = (bc + 1) % 4;
            pops++;
            if (pops == 1) first_pop = cyc;
            last_pop = cyc;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", 32'(fifo_rd), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_data", 32'(m_data), 0);
        chk("rst_last", 32'(m_last), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        arm = 1'b1;
        pops = 0;
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        arm = 1'b0;
        chk("t1_latency", t_v - t_ne, 2);
        chk("t1_beats", pops, 3);
        chk("t1_consec", last_pop - first_pop, 2);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_left", exp_q.size(), 0);

        step(1'b0, 8'h00, 1'b0, 1'b1);
        pops = 0;
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t2_beats", pops, 8);
        chk("t2_consec", last_pop - first_pop, 7);
        chk("t2_left", exp_q.size(), 0);

        pops = 0;
        n = 0;
        for (int i = 0; i < 1000 && (n < 64 || exp_q.size() != 0); i++) begin
            w3 = (n < 64) && ($urandom_range(0, 2) != 0);
            step(w3, 8'(8'h40 + n), $urandom_range(0, 3) != 0, 1'b0);
            if (wr) n++;
        end
        chk("t3_written", n, 64);
        chk("t3_beats", pops, 64);
        chk("t3_left", exp_q.size(), 0);

        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        flush_on_valid = 1'b1;
        pops = 0;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_flush_seen", 32'(flush_on_valid), 0);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_beats", pops, 4);
        chk("t4_left", exp_q.size(), 0);

        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hB0 + i), 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rd", 32'(fifo_rd), 0);
        chk("t5_valid", 32'(m_valid), 0);
        chk("t5_data", 32'(m_data), 0);
        chk("t5_last", 32'(m_last), 0);
        chk("t5_busy", 32'(busy), 0);
        exp_q.delete();
        bc = 0;
        hold = 1'b0;
        wr = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_rd_held", 32'(fifo_rd), 0);
        rst_n = 1'b1;
        pops = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_beats", pops, 4);
        chk("t5_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
